// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, jalr/branch redirect and the EX/MEM register.
// Define EXEC_MULDIV_EN to add the iterative RV32M multiply/divide unit.
module execute_stage #(
    parameter int XLEN   = 32,
    parameter int MD_CYC = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_in,
    input  logic            store_in,
    input  logic            jalr_in,
    input  logic            next_sel_in,
    input  logic            branch_result_in,
    input  logic            reg_write_in,
    input  logic [3:0]      alu_control_in,
    input  logic [1:0]      mem_to_reg_in,
    input  logic [XLEN-1:0] opa_in,
    input  logic [XLEN-1:0] opb_in,
    input  logic [XLEN-1:0] opb_data_in,
    input  logic [XLEN-1:0] pre_address_in,
    input  logic [31:0]     instruction_in,
    input  logic            stall_in,
    input  logic            flush_in,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic            load,
    output logic            store,
    output logic            reg_write,
    output logic [1:0]      mem_to_reg,
    output logic [4:0]      rd_out,
    output logic [31:0]     instruction_out,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    output logic            stall_req
);

    if (XLEN != 32 || MD_CYC < 1) begin : g_bad_cfg
        $error("execute_stage: XLEN must be 32 and MD_CYC >= 1");
    end

    logic            live;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] ex_val;
    logic [XLEN-1:0] sum_ab;

    assign live   = (instruction_in != 32'd0);
    assign sum_ab = opa_in + opb_in;

    always_comb begin
        alu_out = '0;
        unique case (alu_control_in)
            4'd0:    alu_out = sum_ab;
            4'd1:    alu_out = opa_in - opb_in;
            4'd2:    alu_out = opa_in << opb_in[4:0];
            4'd3:    alu_out = {{(XLEN-1){1'b0}},
                                $signed(opa_in) < $signed(opb_in)};
            4'd4:    alu_out = {{(XLEN-1){1'b0}}, opa_in < opb_in};
            4'd5:    alu_out = opa_in ^ opb_in;
            4'd6:    alu_out = opa_in >> opb_in[4:0];
            4'd7:    alu_out = $signed(opa_in) >>> opb_in[4:0];
            4'd8:    alu_out = opa_in | opb_in;
            4'd9:    alu_out = opa_in & opb_in;
            4'd10:   alu_out = opb_in;
            default: alu_out = '0;
        endcase
    end

    assign redirect_valid  = (jalr_in | branch_result_in) & live & ~stall_req;
    assign redirect_target = {sum_ab[XLEN-1:1], sum_ab[0] & ~jalr_in};

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
    localparam int CW = $clog2(MD_CYC + 1);

    md_state_t       state, state_nx;
    logic [CW-1:0]   count;
    logic            is_m, md_start, md_sel;
    logic [2:0]      f3_in, f3;
    logic            a_sgn, b_sgn, a_neg, b_neg, div0;
    logic [31:0]     a_mag, b_mag, acc, lo, mcand, dividend;
    logic [32:0]     sum, rem_sh, diff;
    logic            fits;
    logic [63:0]     prod, prod_s;
    logic [31:0]     quo_s, rem_s, md_result;

    assign f3_in = instruction_in[14:12];
    assign is_m  = (instruction_in[6:0] == 7'b0110011) &&
                   (instruction_in[31:25] == 7'b0000001);
    assign a_sgn = opa_in[31] & (f3_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    assign b_sgn = opb_in[31] & (f3_in inside {3'd0, 3'd1, 3'd4, 3'd6});
    assign a_mag = a_sgn ? -opa_in : opa_in;
    assign b_mag = b_sgn ? -opb_in : opb_in;

    always_comb begin
        state_nx  = state;
        stall_req = 1'b0;
        md_start  = 1'b0;
        md_sel    = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_m && live && !flush_in) begin
                    stall_req = 1'b1;
                    md_start  = 1'b1;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (count == CW'(MD_CYC - 1))
                    state_nx = DONE;
            end
            DONE: begin
                md_sel = 1'b1;
                if (!stall_in)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush_in)
            state_nx = IDLE;
    end

    // {acc, lo} is the product shift register or the remainder/quotient pair
    assign sum    = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : 33'd0);
    assign rem_sh = {acc, lo[31]};
    assign diff   = rem_sh - {1'b0, mcand};
    assign fits   = (rem_sh >= {1'b0, mcand});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            lo       <= '0;
            mcand    <= '0;
            dividend <= '0;
            f3       <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div0     <= 1'b0;
        end else begin
            state <= state_nx;
            if (md_start) begin
                count    <= '0;
                acc      <= '0;
                lo       <= f3_in[2] ? a_mag : b_mag;
                mcand    <= f3_in[2] ? b_mag : a_mag;
                dividend <= opa_in;
                f3       <= f3_in;
                a_neg    <= a_sgn;
                b_neg    <= b_sgn;
                div0     <= (opb_in == 32'd0);
            end else if (state == BUSY) begin
                count <= count + 1'b1;
                if (!f3[2]) begin
                    acc <= sum[32:1];
                    lo  <= {sum[0], lo[31:1]};
                end else begin
                    acc <= fits ? diff[31:0] : rem_sh[31:0];
                    lo  <= {lo[30:0], fits};
                end
            end
        end
    end

    assign prod   = {acc, lo};
    assign prod_s = (a_neg ^ b_neg) ? -prod : prod;
    assign quo_s  = (a_neg ^ b_neg) ? -lo : lo;
    assign rem_s  = a_neg ? -acc : acc;

    always_comb begin
        md_result = '0;
        unique case (f3)
            3'd0:                md_result = prod_s[31:0];
            3'd1, 3'd2, 3'd3:    md_result = prod_s[63:32];
            3'd4, 3'd5:          md_result = div0 ? 32'hFFFF_FFFF : quo_s;
            default:             md_result = div0 ? dividend : rem_s;
        endcase
    end

    assign ex_val = md_sel ? md_result : alu_out;
`else
    assign stall_req = 1'b0;
    assign ex_val    = alu_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result      <= '0;
            store_data      <= '0;
            load            <= 1'b0;
            store           <= 1'b0;
            reg_write       <= 1'b0;
            mem_to_reg      <= '0;
            rd_out          <= '0;
            instruction_out <= '0;
        end else if (flush_in || (!stall_in && !stall_req && !live)) begin
            alu_result      <= '0;
            store_data      <= '0;
            load            <= 1'b0;
            store           <= 1'b0;
            reg_write       <= 1'b0;
            mem_to_reg      <= '0;
            rd_out          <= '0;
            instruction_out <= '0;
        end else if (!stall_in && !stall_req) begin
            alu_result      <= next_sel_in ? pre_address_in + 32'd4 : ex_val;
            store_data      <= opb_data_in;
            load            <= load_in;
            store           <= store_in;
            reg_write       <= reg_write_in;
            mem_to_reg      <= mem_to_reg_in;
            rd_out          <= instruction_in[11:7];
            instruction_out <= instruction_in;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed steps plus random ALU traffic vs a model.
// Extra multiply/divide steps run when EXEC_MULDIV_EN is defined.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_in, store_in, jalr_in, next_sel_in;
    logic        branch_result_in, reg_write_in;
    logic [3:0]  alu_control_in;
    logic [1:0]  mem_to_reg_in;
    logic [31:0] opa_in, opb_in, opb_data_in, pre_address_in, instruction_in;
    logic        stall_in, flush_in;
    logic [31:0] alu_result, store_data;
    logic        load, store, reg_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd_out;
    logic [31:0] instruction_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall_req;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] e_alu, e_sd, e_ins;
    logic [4:0]  e_ctl;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .load_in(load_in), .store_in(store_in), .jalr_in(jalr_in),
        .next_sel_in(next_sel_in), .branch_result_in(branch_result_in),
        .reg_write_in(reg_write_in), .alu_control_in(alu_control_in),
        .mem_to_reg_in(mem_to_reg_in), .opa_in(opa_in), .opb_in(opb_in),
        .opb_data_in(opb_data_in), .pre_address_in(pre_address_in),
        .instruction_in(instruction_in), .stall_in(stall_in),
        .flush_in(flush_in), .alu_result(alu_result),
        .store_data(store_data), .load(load), .store(store),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .rd_out(rd_out),
        .instruction_out(instruction_out),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return sa >>> b[4:0];
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_ref(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] xa, xb, p;
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        xa  = (f3 == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
        xb  = (f3 >= 3'd2) ? {32'd0, b} : {{32{b[31]}}, b};
        p   = xa * xb;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_alu"}, alu_result, e_alu);
        chk({tag, "_sd"}, store_data, e_sd);
        chk({tag, "_ctl"}, {27'd0, load, store, reg_write, mem_to_reg},
            {27'd0, e_ctl});
        chk({tag, "_rd"}, {27'd0, rd_out}, {27'd0, e_ins[11:7]});
        chk({tag, "_ins"}, instruction_out, e_ins);
    endtask

    // one cycle: check redirect, advance the model, clock, check EX/MEM
    task automatic ex_cycle(input string tag);
        logic [31:0] s;
        logic        rv;
        #1;
        s  = opa_in + opb_in;
        rv = (jalr_in || branch_result_in) && (instruction_in != 0);
        chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, "_rt"}, redirect_target, jalr_in ? (s & ~32'd1) : s);
        if (flush_in || (!stall_in && instruction_in == 0)) begin
            e_alu = 0; e_sd = 0; e_ctl = 0; e_ins = 0;
        end else if (!stall_in) begin
            e_alu = next_sel_in ? pre_address_in + 32'd4
                                : alu_ref(alu_control_in, opa_in, opb_in);
            e_sd  = opb_data_in;
            e_ctl = {load_in, store_in, reg_write_in, mem_to_reg_in};
            e_ins = instruction_in;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic rand_inputs();
        load_in          = 1'($urandom);
        store_in         = 1'($urandom);
        jalr_in          = ($urandom_range(0, 3) == 0);
        next_sel_in      = ($urandom_range(0, 3) == 0);
        branch_result_in = ($urandom_range(0, 3) == 0);
        reg_write_in     = 1'($urandom);
        alu_control_in   = 4'($urandom);
        mem_to_reg_in    = 2'($urandom);
        opa_in           = $urandom;
        opb_in           = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                                      : $urandom;
        opb_data_in      = $urandom;
        pre_address_in   = $urandom & 32'hFFFF_FFFC;
        instruction_in   = {$urandom} & 32'hFFFF_FF80 | 32'h13;
        if ($urandom_range(0, 7) == 0)
            instruction_in = 0;
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic run_m(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
        int n;
        logic [31:0] exp;
        exp = m_ref(f3, a, b);
        instruction_in   = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
        opa_in           = a;
        opb_in           = b;
        alu_control_in   = 4'd0;
        next_sel_in      = 1'b0;
        jalr_in          = 1'b0;
        branch_result_in = 1'b0;
        reg_write_in     = 1'b1;
        load_in          = 1'b0;
        store_in         = 1'b0;
        mem_to_reg_in    = 2'd0;
        stall_in         = 1'b0;
        flush_in         = 1'b0;
        opb_data_in      = $urandom;
        #1;
        n = 0;
        while (stall_req && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("m_stall_cycles", 32'(n), 32'd33);
        @(posedge clk);
        #1;
        e_alu = exp;
        e_sd  = opb_data_in;
        e_ctl = 5'b00100;
        e_ins = instruction_in;
        check_regs("m_result");
        instruction_in = 0;
        ex_cycle("m_bubble");
    endtask
`endif

    initial begin
        rst = 1'b0;
        load_in = 1; store_in = 1; jalr_in = 0; next_sel_in = 0;
        branch_result_in = 0; reg_write_in = 1; alu_control_in = 0;
        mem_to_reg_in = 2'd3; opa_in = 5; opb_in = 7; opb_data_in = 32'hAA;
        pre_address_in = 32'h100; instruction_in = 32'h0000_0193;
        stall_in = 0; flush_in = 0;
        e_alu = 0; e_sd = 0; e_ctl = 0; e_ins = 0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        chk("reset_stall_req", {31'd0, stall_req}, 32'd0);

        // add 5+7
        rst = 1'b1;
        ex_cycle("t1");
        chk("t1_add12", alu_result, 32'd12);

        alu_control_in = 4'd7; opa_in = 32'h8000_0000; opb_in = 4;
        ex_cycle("t2_sra");
        chk("t2_sra_val", alu_result, 32'hF800_0000);
        alu_control_in = 4'd4; opa_in = 1; opb_in = 32'hFFFF_FFFF;
        ex_cycle("t2_sltu");
        chk("t2_sltu_val", alu_result, 32'd1);

        jalr_in = 1; next_sel_in = 1; alu_control_in = 0;
        opa_in = 32'h101; opb_in = 4; pre_address_in = 32'h40;
        instruction_in = 32'h0000_80E7;
        #1;
        chk("t3_redirect", redirect_target, 32'h104);
        ex_cycle("t3_jalr");
        chk("t3_link", alu_result, 32'h44);

        stall_in = 1; jalr_in = 0; next_sel_in = 0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            jalr_in = 0;
            ex_cycle("t4_stall");
        end
        chk("t4_hold", alu_result, 32'h44);
        flush_in = 1;
        ex_cycle("t4_flush");
        chk("t4_flushed", alu_result, 32'd0);
        stall_in = 0; flush_in = 0;

        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            stall_in = ($urandom_range(0, 9) == 0);
            flush_in = ($urandom_range(0, 15) == 0);
            ex_cycle("rnd");
        end
        stall_in = 0; flush_in = 0;

`ifdef EXEC_MULDIV_EN
        run_m(3'd4, 32'd7, 32'd0);
        run_m(3'd0, 32'hFFFF_FFFF, 32'd2);
        run_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++)
            run_m(3'(i), $urandom, $urandom);

        instruction_in = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        opa_in = 32'd3; opb_in = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        chk("f_busy", {31'd0, stall_req}, 32'd1);
        flush_in = 1;
        instruction_in = 0;
        @(posedge clk);
        #1;
        chk("f_stall_req", {31'd0, stall_req}, 32'd0);
        e_alu = 0; e_sd = 0; e_ctl = 0; e_ins = 0;
        check_regs("f_bubble");
        flush_in = 0;
        ex_cycle("f_after");
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
